// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_pkg
// Brief    : Shared constants for the I2C bus-activity monitor: bus-state
//            encodings and counter widths.
// Revision : 1.0 - initial release
// ============================================================================
package i2c_pkg;

  // Glitch-filter persistence counter width (covers FILT_LEN up to 15)
  localparam int FILT_CNT_W = 4;

  // Width of the activity-stretch and bus-free counters
  localparam int CNT_W = 16;

  // Bus-state encodings as presented on o_bus_state
  localparam logic [1:0] BUS_IDLE      = 2'b00;
  localparam logic [1:0] BUS_BUSY      = 2'b01;
  localparam logic [1:0] BUS_FREE_WAIT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE      = BUS_IDLE,
    ST_BUSY      = BUS_BUSY,
    ST_FREE_WAIT = BUS_FREE_WAIT
  } bus_state_e;

endpackage
`default_nettype wire

// File: rtl/i2c_sync_filter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_sync_filter
// Brief    : Multi-stage synchroniser followed by a persistence glitch filter
//            for one raw open-drain pad line. Idles (and resets) high.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_sync_filter
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic i_sys_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_filt
);

  // Counter value at which a persisting difference is accepted
  localparam logic [FILT_CNT_W-1:0] FILT_LAST = FILT_CNT_W'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_w;
  logic [FILT_CNT_W-1:0]  cnt_q, cnt_d;
  logic                   filt_q, filt_d;

  assign sync_w = sync_q[SYNC_STAGES-1];
  assign o_filt = filt_q;

  // Shift the asynchronous pad level through the synchroniser chain
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_raw};
    end
  end

  // Count how long the synchronised level has disagreed with the filtered one
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync_w != filt_q) begin
      if (cnt_q >= FILT_LAST) begin
        filt_d = sync_w;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Filter state registers
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_bus_activity_mon.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_activity_mon
// Brief    : Always-on I2C bus monitor. Filters SCL/SDA, detects START/STOP,
//            tracks bus ownership and produces a stretched activity level
//            for the power manager's wake/idle logic.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_bus_activity_mon
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int FILT_LEN        = 3,
  parameter int HOLD_CYCLES     = 16,
  parameter int BUS_FREE_CYCLES = 64
) (
  input  logic       i_sys_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  input  logic       i_sda,
  input  logic       i_enable,
  output logic       o_scl_filt,
  output logic       o_sda_filt,
  output logic       o_start_det,
  output logic       o_stop_det,
  output logic       o_bus_activity,
  output logic       o_bus_busy,
  output logic [1:0] o_bus_state
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] FREE_LAST = CNT_W'(BUS_FREE_CYCLES);

  logic scl_f_w, sda_f_w;

  i2c_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_scl_filt (
    .i_sys_clk (i_sys_clk),
    .i_rst     (i_rst),
    .i_raw     (i_scl),
    .o_filt    (scl_f_w)
  );

  i2c_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_sda_filt (
    .i_sys_clk (i_sys_clk),
    .i_rst     (i_rst),
    .i_raw     (i_sda),
    .o_filt    (sda_f_w)
  );

  assign o_scl_filt = scl_f_w;
  assign o_sda_filt = sda_f_w;

  // Previous filtered levels for edge detection
  logic scl_q, sda_q;

  // Keep tracking the filtered lines even when disabled so re-enable is clean
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f_w;
      sda_q <= sda_f_w;
    end
  end

  // A simultaneous SCL change fails the scl_q & scl term, so it masks both
  logic start_w, stop_w, scl_fall_w, edge_w, lines_high_w;
  assign start_w      = scl_q & scl_f_w & sda_q & ~sda_f_w;
  assign stop_w       = scl_q & scl_f_w & ~sda_q & sda_f_w;
  assign scl_fall_w   = scl_q & ~scl_f_w;
  assign edge_w       = (scl_q != scl_f_w) | (sda_q != sda_f_w);
  assign lines_high_w = scl_f_w & sda_f_w;

  bus_state_e       state_q, state_d;
  logic [CNT_W-1:0] free_q, free_d, free_inc_w;
  logic [CNT_W-1:0] hold_q, hold_d;

  // free_q never exceeds BUS_FREE_CYCLES-1, so the increment cannot wrap
  assign free_inc_w = free_q + 1'b1;

  // Bus-ownership next state and bus-free timer
  always_comb begin
    state_d = state_q;
    free_d  = '0;
    if (!i_enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_w || scl_fall_w) state_d = ST_BUSY;
        end
        ST_BUSY: begin
          if (stop_w) state_d = ST_FREE_WAIT;
        end
        ST_FREE_WAIT: begin
          if (start_w || !lines_high_w) begin
            state_d = ST_BUSY;
          end else if (free_inc_w >= FREE_LAST) begin
            state_d = ST_IDLE;
          end else begin
            free_d = free_inc_w;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Bus-state and bus-free counter registers
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      free_q  <= '0;
    end else begin
      state_q <= state_d;
      free_q  <= free_d;
    end
  end

  // Activity stretch: reload on any filtered edge (reload beats terminal count)
  always_comb begin
    hold_d = '0;
    if (i_enable) begin
      if (edge_w) begin
        hold_d = HOLD_LOAD;
      end else if (hold_q != '0) begin
        hold_d = hold_q - 1'b1;
      end
    end
  end

  logic       start_det_q, stop_det_q, activity_q, busy_q;
  logic [1:0] state_out_q;

  // Registered outputs; detection and activity are suppressed while disabled
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_q      <= '0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      activity_q  <= 1'b0;
      busy_q      <= 1'b0;
      state_out_q <= BUS_IDLE;
    end else begin
      hold_q      <= hold_d;
      start_det_q <= i_enable & start_w;
      stop_det_q  <= i_enable & stop_w;
      activity_q  <= i_enable & ((hold_q != '0) | (state_q == ST_BUSY));
      busy_q      <= (state_q != ST_IDLE);
      state_out_q <= state_q;
    end
  end

  assign o_start_det    = start_det_q;
  assign o_stop_det     = stop_det_q;
  assign o_bus_activity = activity_q;
  assign o_bus_busy     = busy_q;
  assign o_bus_state    = state_out_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_activity_mon.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_i2c_bus_activity_mon
// Brief    : Directed scoreboard bench for i2c_bus_activity_mon (defaults).
//            START/STOP pulses are predicted into a queue with their expected
//            cycle; a negedge monitor pops and compares every pulse seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_bus_activity_mon;

  localparam int EV_START = 0;
  localparam int EV_STOP  = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       sda = 1'b1;
  logic       en  = 1'b1;
  logic       o_scl_filt, o_sda_filt, o_start_det, o_stop_det;
  logic       o_bus_activity, o_bus_busy;
  logic [1:0] o_bus_state;

  i2c_bus_activity_mon #(
    .SYNC_STAGES     (2),
    .FILT_LEN        (3),
    .HOLD_CYCLES     (16),
    .BUS_FREE_CYCLES (64)
  ) dut (
    .i_sys_clk      (clk),
    .i_rst          (rst),
    .i_scl          (scl),
    .i_sda          (sda),
    .i_enable       (en),
    .o_scl_filt     (o_scl_filt),
    .o_sda_filt     (o_sda_filt),
    .o_start_det    (o_start_det),
    .o_stop_det     (o_stop_det),
    .o_bus_activity (o_bus_activity),
    .o_bus_busy     (o_bus_busy),
    .o_bus_state    (o_bus_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_check(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, expected none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("pulse_kind", kind, e.kind);
      chk("pulse_cycle", cyc, e.at);
    end
  endtask

  // Monitor: every START/STOP pulse must match the head of the prediction queue
  always @(negedge clk) begin
    if (!rst) begin
      if (o_start_det) pop_check(EV_START);
      if (o_stop_det)  pop_check(EV_STOP);
    end
  end

  // Advance n rising edges and settle just after the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Predict a pulse 'dly' edges after the edge that preceded the current drive
  task automatic expect_ev(input int kind, input int dly);
    exp_q.push_back('{kind: kind, at: cyc + dly});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_scl_filt"}, o_scl_filt, 1);
    chk({tag, "_sda_filt"}, o_sda_filt, 1);
    chk({tag, "_start"},    o_start_det, 0);
    chk({tag, "_stop"},     o_stop_det, 0);
    chk({tag, "_activity"}, o_bus_activity, 0);
    chk({tag, "_busy"},     o_bus_busy, 0);
    chk({tag, "_state"},    o_bus_state, 0);
  endtask

  int flt_low;

  initial begin
    rst = 1'b1;
    tick(3);
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick(10);
    chk("idle_state", o_bus_state, 0);
    chk("idle_activity", o_bus_activity, 0);

    // 2-cycle SDA glitch while SCL high: fully suppressed
    sda = 1'b0;
    tick(2);
    sda = 1'b1;
    flt_low = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (o_sda_filt !== 1'b1) flt_low = 1;
    end
    chk("glitch2_sda_filt_low", flt_low, 0);
    chk("glitch2_state", o_bus_state, 0);

    // 3-cycle SDA low: START, then the filtered release gives STOP
    expect_ev(EV_START, 6);
    expect_ev(EV_STOP, 9);
    sda = 1'b0;
    tick(3);
    sda = 1'b1;
    tick(4);
    chk("glitch3_state_busy", o_bus_state, 1);
    tick(90);
    chk("glitch3_back_idle", o_bus_state, 0);

    // Clean START: pulse 6 edges after drive, state 01 one edge later
    sda = 1'b0;
    expect_ev(EV_START, 6);
    tick(5);
    chk("start_filt_sda", o_sda_filt, 0);
    tick(1);
    chk("start_pulse_level", o_start_det, 1);
    chk("start_state_before", o_bus_state, 0);
    tick(1);
    chk("start_state", o_bus_state, 1);
    chk("start_busy", o_bus_busy, 1);
    chk("start_activity", o_bus_activity, 1);

    // Repeated START keeps state BUSY
    scl = 1'b0; tick(8);
    chk("rs_scl_low_state", o_bus_state, 1);
    sda = 1'b1; tick(8);
    scl = 1'b1; tick(8);
    chk("rs_scl_high_state", o_bus_state, 1);
    sda = 1'b0;
    expect_ev(EV_START, 6);
    tick(8);
    chk("rs_state", o_bus_state, 1);

    // STOP -> FREE_WAIT, then START at FREE_WAIT cycle ~30 -> BUSY
    scl = 1'b0; tick(8);
    scl = 1'b1; tick(8);
    sda = 1'b1;
    expect_ev(EV_STOP, 6);
    tick(7);
    chk("stop1_state_fw", o_bus_state, 2);
    tick(24);
    sda = 1'b0;
    expect_ev(EV_START, 6);
    tick(6);
    chk("fw_start_state_before", o_bus_state, 2);
    tick(1);
    chk("fw_start_state_busy", o_bus_state, 1);

    // Final STOP, lines held high: activity and bus-free timing
    sda = 1'b1;
    expect_ev(EV_STOP, 6);
    tick(7);
    chk("stop2_state_fw", o_bus_state, 2);
    tick(15);
    chk("stretch_last_high", o_bus_activity, 1);
    tick(1);
    chk("stretch_dropped", o_bus_activity, 0);
    tick(47);
    chk("free_wait_still", o_bus_state, 2);
    chk("free_wait_busy", o_bus_busy, 1);
    tick(1);
    chk("free_to_idle", o_bus_state, 0);
    chk("free_idle_busy", o_bus_busy, 0);

    // Disabled: filters follow, no detection, state held IDLE
    en = 1'b0;
    tick(2);
    scl = 1'b0;
    tick(5);
    chk("dis_scl_filt_low", o_scl_filt, 0);
    tick(3);
    chk("dis_state", o_bus_state, 0);
    chk("dis_activity", o_bus_activity, 0);
    scl = 1'b1;
    tick(5);
    chk("dis_scl_filt_high", o_scl_filt, 1);
    sda = 1'b0; tick(8);
    sda = 1'b1; tick(8);
    chk("dis_state2", o_bus_state, 0);
    chk("dis_activity2", o_bus_activity, 0);
    en = 1'b1;
    tick(20);
    chk("reen_state", o_bus_state, 0);
    chk("reen_activity", o_bus_activity, 0);

    // Asynchronous reset mid-byte with SCL toggling
    sda = 1'b0;
    expect_ev(EV_START, 6);
    tick(8);
    chk("mid_state_busy", o_bus_state, 1);
    repeat (3) begin
      scl = 1'b0; tick(4);
      scl = 1'b1; tick(4);
    end
    scl = 1'b0;
    tick(6);
    chk("mid_scl_filt_low", o_scl_filt, 0);
    #1 rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    scl = 1'b1;
    sda = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(30);
    chk("post_rst_state", o_bus_state, 0);
    chk("post_rst_activity", o_bus_activity, 0);

    tick(5);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
